// File: rtl/parity_pkg.sv
// Shared definitions for the serial parity frame checker: FSM encoding,
// parity mode constants and the error-counter width.
package parity_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    localparam int ERR_CNT_W = 8;

    // Expected parity bit for an accumulated XOR under the selected mode.
    function automatic logic expected_parity(input logic acc, input logic odd);
        return acc ^ odd;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/serial_parity_frame.sv
// Serial parity checker: XORs FRAME_LEN data bits, compares a trailing parity bit.
// Optional saturating error counter on err_count when PARITY_ERR_COUNT_EN is defined.
module serial_parity_frame
    import parity_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter int ODD       = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    input  logic                             in_bit,
    output logic                             in_ready,
    input  logic                             abort,
    output logic                             out_valid,
    output logic                             parity_out,
    output logic                             parity_err,
    output logic [$clog2(FRAME_LEN+1)-1:0]   bit_count,
    output state_t                           dbg_state
`ifdef PARITY_ERR_COUNT_EN
    ,
    output logic [ERR_CNT_W-1:0]             err_count
`endif
);

    localparam int                CNT_W   = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0]  LAST    = CNT_W'(FRAME_LEN);
    localparam logic              ODD_BIT = (ODD != 0) ? PARITY_ODD : PARITY_EVEN;

    state_t           state, state_nxt;
    logic             acc, acc_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             po_nxt, pe_nxt;
    logic             accept;

    // Handshake: a bit transfers on a rising edge with in_valid && in_ready;
    // in_ready drops only for the single DONE cycle, and upstream holds its bit.
    assign in_ready  = ~out_valid;
    assign accept    = in_valid & in_ready;
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = bit_count;
        po_nxt    = parity_out;
        pe_nxt    = parity_err;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    acc_nxt   = in_bit;
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = (FRAME_LEN == 1) ? ST_PARITY : ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    acc_nxt = acc ^ in_bit;
                    cnt_nxt = bit_count + 1'b1;
                    if (cnt_nxt == LAST) begin
                        state_nxt = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (accept) begin
                    po_nxt    = expected_parity(acc, ODD_BIT);
                    pe_nxt    = expected_parity(acc, ODD_BIT) ^ in_bit;
                    state_nxt = ST_DONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                acc_nxt   = 1'b0;
                cnt_nxt   = '0;
            end
        endcase
        // Abort wins over a same-cycle accept; the reported result is left alone.
        if (abort) begin
            state_nxt = ST_IDLE;
            acc_nxt   = 1'b0;
            cnt_nxt   = '0;
            po_nxt    = parity_out;
            pe_nxt    = parity_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            acc        <= 1'b0;
            bit_count  <= '0;
            parity_out <= 1'b0;
            parity_err <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            bit_count  <= cnt_nxt;
            parity_out <= po_nxt;
            parity_err <= pe_nxt;
            out_valid  <= (state_nxt == ST_DONE);
        end
    end

`ifdef PARITY_ERR_COUNT_EN
    sat_counter #(
        .W(ERR_CNT_W)
    ) u_err_count (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid & parity_err),
        .count (err_count)
    );
`endif

endmodule

// File: tb/tb_serial_parity_frame.sv
// Bench for serial_parity_frame: three instances (8/even, 8/odd, 1/even) against a
// frame-level reference model with a result queue drained by per-instance monitors.
module tb_serial_parity_frame;
    import parity_pkg::*;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       in_valid [N];
    logic       in_bit   [N];
    logic       abort    [N];
    logic       in_ready [N];
    logic       out_valid[N];
    logic       parity_out[N];
    logic       parity_err[N];
    logic [7:0] bcnt[N];
    logic [1:0] st[N];
    logic [7:0] ec[N];

    // Reference model: data bits of the frame in progress, pending results.
    logic [1:0] exp_q[N][$];
    bit         dq[N][$];
    bit         mdone[N];
    bit         pend[N];
    logic       m_po[N];
    logic       m_pe[N];
    int         m_err[N];
    bit         mon_en;

    int n_checks;
    int n_fail;

    function automatic int fl(input int g);
        return (g == 2) ? 1 : 8;
    endfunction

    function automatic bit od(input int g);
        return (g == 1);
    endfunction

    function automatic bit model_parity(input int g);
        bit p = od(g);
        for (int i = 0; i < dq[g].size(); i++) p ^= dq[g][i];
        return p;
    endfunction

    function automatic int exp_state(input int g);
        if (mdone[g]) return int'(ST_DONE);
        if (dq[g].size() == 0) return int'(ST_IDLE);
        if (dq[g].size() < fl(g)) return int'(ST_DATA);
        return int'(ST_PARITY);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    generate
        for (genvar g = 0; g < N; g++) begin : gi
            localparam int L = (g == 2) ? 1 : 8;
            localparam int O = (g == 1) ? 1 : 0;
            logic [$clog2(L+1)-1:0] bc;
            state_t                 ds;
            logic [1:0]             e;

            serial_parity_frame #(
                .FRAME_LEN(L),
                .ODD(O)
            ) dut (
                .clk        (clk),
                .rst        (rst),
                .in_valid   (in_valid[g]),
                .in_bit     (in_bit[g]),
                .in_ready   (in_ready[g]),
                .abort      (abort[g]),
                .out_valid  (out_valid[g]),
                .parity_out (parity_out[g]),
                .parity_err (parity_err[g]),
                .bit_count  (bc),
                .dbg_state  (ds)
`ifdef PARITY_ERR_COUNT_EN
                ,
                .err_count  (ec[g])
`endif
            );

            assign bcnt[g] = 8'(bc);
            assign st[g]   = ds;
`ifndef PARITY_ERR_COUNT_EN
            assign ec[g] = 8'd0;
`endif

            // Monitor: compares every cycle and drains the result queue on out_valid.
            always @(negedge clk) begin
                if (!rst && mon_en) begin
                    check($sformatf("g%0d in_ready", g), int'(in_ready[g]), int'(!mdone[g]));
                    check($sformatf("g%0d out_valid", g), int'(out_valid[g]), int'(mdone[g]));
                    check($sformatf("g%0d bit_count", g), int'(bcnt[g]), dq[g].size());
                    check($sformatf("g%0d state", g), int'(st[g]), exp_state(g));
                    check($sformatf("g%0d parity_out hold", g), int'(parity_out[g]), int'(m_po[g]));
                    check($sformatf("g%0d parity_err hold", g), int'(parity_err[g]), int'(m_pe[g]));
`ifdef PARITY_ERR_COUNT_EN
                    check($sformatf("g%0d err_count", g), int'(ec[g]), m_err[g]);
`endif
                    if (out_valid[g]) begin
                        if (exp_q[g].size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL g%0d result: got out_valid expected no pending frame", g);
                        end else begin
                            e = exp_q[g].pop_front();
                            check($sformatf("g%0d result parity_out", g), int'(parity_out[g]), int'(e[0]));
                            check($sformatf("g%0d result parity_err", g), int'(parity_err[g]), int'(e[1]));
                        end
                    end
                end
            end
        end
    endgenerate

    // One clock of stimulus: model consumes the inputs presented at this edge.
    task automatic step();
        @(posedge clk);
        for (int g = 0; g < N; g++) begin
            bit prev = mdone[g];
            mdone[g] = 1'b0;
            if (prev) begin
                if (m_pe[g] && m_err[g] < 255) m_err[g]++;
                dq[g].delete();
            end else if (abort[g]) begin
                dq[g].delete();
            end else if (in_valid[g]) begin
                if (dq[g].size() < fl(g)) begin
                    dq[g].push_back(in_bit[g]);
                end else begin
                    m_po[g] = model_parity(g);
                    m_pe[g] = m_po[g] ^ in_bit[g];
                    exp_q[g].push_back({m_pe[g], m_po[g]});
                    mdone[g] = 1'b1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic send_bit(input int g, input bit b);
        bit took;
        int guard = 0;
        in_valid[g] = 1'b1;
        in_bit[g]   = b;
        do begin
            took = !mdone[g] && !abort[g];
            step();
            guard++;
        end while (!took && guard < 4);
        in_valid[g] = 1'b0;
    endtask

    task automatic send_frame(input int g, input logic [7:0] data, input bit par);
        for (int i = 0; i < fl(g); i++) send_bit(g, data[i]);
        send_bit(g, par);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_cleared(input string tag);
        for (int g = 0; g < N; g++) begin
            check($sformatf("%s g%0d out_valid", tag, g), int'(out_valid[g]), 0);
            check($sformatf("%s g%0d parity_out", tag, g), int'(parity_out[g]), 0);
            check($sformatf("%s g%0d parity_err", tag, g), int'(parity_err[g]), 0);
            check($sformatf("%s g%0d bit_count", tag, g), int'(bcnt[g]), 0);
`ifdef PARITY_ERR_COUNT_EN
            check($sformatf("%s g%0d err_count", tag, g), int'(ec[g]), 0);
`endif
        end
    endtask

    task automatic clear_model();
        for (int g = 0; g < N; g++) begin
            dq[g].delete();
            exp_q[g].delete();
            mdone[g] = 1'b0;
            pend[g]  = 1'b0;
            m_po[g]  = 1'b0;
            m_pe[g]  = 1'b0;
            m_err[g] = 0;
            in_valid[g] = 1'b0;
            in_bit[g]   = 1'b0;
            abort[g]    = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] d;
        n_checks = 0;
        n_fail   = 0;
        mon_en   = 1'b0;
        rst      = 1'b1;
        clear_model();

        // Asynchronous reset before any clock edge.
        #3;
        check_cleared("reset");
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        #1;
        for (int g = 0; g < N; g++) check($sformatf("g%0d in_ready after reset", g), int'(in_ready[g]), 1);

        // Good and bad frames, even mode; back-to-back bits.
        send_frame(0, 8'b0000_1101, 1'b1);
        send_frame(0, 8'b0000_1101, 1'b0);
        idle(2);

        // Odd mode, all-zero data, parity 1 is correct.
        send_frame(1, 8'h00, 1'b1);
        idle(2);

        // Abort after 5 data bits with a simultaneous valid bit, then a good frame.
        for (int i = 0; i < 5; i++) send_bit(0, 1'b1);
        in_valid[0] = 1'b1;
        in_bit[0]   = 1'b1;
        abort[0]    = 1'b1;
        step();
        abort[0]    = 1'b0;
        in_valid[0] = 1'b0;
        idle(1);
        send_frame(0, 8'b1010_0110, 1'b0);

        // Stall of 3 cycles mid-frame.
        for (int i = 0; i < 4; i++) send_bit(0, 1'(i == 1));
        idle(3);
        for (int i = 0; i < 4; i++) send_bit(0, 1'b1);
        send_bit(0, 1'b1);
        idle(2);

        // Single-bit frames.
        send_frame(2, 8'h01, 1'b1);
        send_frame(2, 8'h01, 1'b0);
        idle(2);

        // Random traffic on all instances with gaps and occasional aborts.
        for (int c = 0; c < 2000; c++) begin
            for (int g = 0; g < N; g++) begin
                if (!pend[g]) begin
                    in_valid[g] = ($urandom_range(0, 3) != 0);
                    in_bit[g]   = 1'($urandom_range(0, 1));
                end
                abort[g] = ($urandom_range(0, 40) == 0);
                pend[g]  = in_valid[g] && mdone[g];
            end
            step();
        end
        for (int g = 0; g < N; g++) begin
            in_valid[g] = 1'b0;
            abort[g]    = 1'b1;
            pend[g]     = 1'b0;
        end
        step();
        for (int g = 0; g < N; g++) abort[g] = 1'b0;
        idle(1);

        // 300 bad frames drive the error counter into saturation.
        for (int f = 0; f < 300; f++) begin
            d = 8'($urandom);
            send_frame(0, d, ~(^d));
        end
        idle(2);
`ifdef PARITY_ERR_COUNT_EN
        check("g0 err_count saturated", int'(ec[0]), 255);
`endif

        // Reset mid-frame, away from the clock edge.
        for (int i = 0; i < 3; i++) send_bit(0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_cleared("mid-frame reset");
        clear_model();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int g = 0; g < N; g++) check($sformatf("g%0d in_ready after reset", g), int'(in_ready[g]), 1);
        send_frame(0, 8'b0000_1101, 1'b1);
        idle(3);

        for (int g = 0; g < N; g++) check($sformatf("g%0d results left pending", g), exp_q[g].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
